// File: rtl/axi4_sync_fifo.sv
// axi4_sync_fifo: single-clock first-word-fall-through FIFO for AXI4 channel buffering.
// Storage is a (DEPTH-1)-word RAM behind a head output register, giving DEPTH entries in total.
// Optional macro AXI4_SYNC_FIFO_ERR_EN adds a sticky overflow/underflow flag on err_o.
module axi4_sync_fifo #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  data_in_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [WIDTH-1:0]  data_out_o,
    output logic              valid_o,
    output logic              full_o,
    output logic              afull_o,
    output logic [ADDR_W:0]   level_o
`ifdef AXI4_SYNC_FIFO_ERR_EN
    ,
    output logic              err_o
`endif
);

    localparam int unsigned       RamDepth = DEPTH - 1;
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W:0]   FullLvl  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AfullLvl = (ADDR_W + 1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0]   TwoLvl   = (ADDR_W + 1)'(2);

    // Backing RAM for everything behind the head entry; not reset.
    logic [WIDTH-1:0]  mem_q [RamDepth];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  out_q, out_d;
`ifdef AXI4_SYNC_FIFO_ERR_EN
    logic              err_q, err_d;
`endif

    logic full;
    logic push_acc;
    logic pop_acc;
    logic ram_empty;
    logic ram_we;
    logic ram_re;

    // Status flags derive only from the registered level.
    always_comb begin
        full      = (level_q == FullLvl);
        // The head register holds one entry, so the RAM is empty while level <= 1.
        ram_empty = (level_q < TwoLvl);
        push_acc  = push_i & ~full;
        pop_acc   = pop_i & valid_q;
    end

    // Next-state logic: routes pushes to the head register or RAM and refills the head on pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        out_d    = out_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
`ifdef AXI4_SYNC_FIFO_ERR_EN
        err_d    = err_q | (push_i & full) | (pop_i & ~valid_q);
`endif

        if (!valid_q) begin
            // Empty: a push lands directly in the head register, no RAM round trip.
            if (push_acc) begin
                out_d   = data_in_i;
                valid_d = 1'b1;
            end
        end else if (pop_acc) begin
            if (!ram_empty) begin
                // Refill the head from RAM; a concurrent push goes behind it into RAM.
                ram_re = 1'b1;
                out_d  = mem_q[rd_ptr_q];
                ram_we = push_acc;
            end else if (push_acc) begin
                out_d = data_in_i;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            ram_we = push_acc;
        end

        if (ram_we) begin
            wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + ADDR_W'(1);
        end
        if (ram_re) begin
            rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + ADDR_W'(1);
        end

        unique case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        // Flush wins over any push or pop in the same cycle.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
            out_d    = '0;
            ram_we   = 1'b0;
`ifdef AXI4_SYNC_FIFO_ERR_EN
            err_d    = 1'b0;
`endif
        end
    end

    // Control and head-register state with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            out_q    <= '0;
`ifdef AXI4_SYNC_FIFO_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
`ifdef AXI4_SYNC_FIFO_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    // RAM write port.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem_q[wr_ptr_q] <= data_in_i;
        end
    end

    // Output mapping.
    always_comb begin
        data_out_o = out_q;
        valid_o    = valid_q;
        level_o    = level_q;
        full_o     = full;
        afull_o    = (level_q >= AfullLvl);
`ifdef AXI4_SYNC_FIFO_ERR_EN
        err_o      = err_q;
`endif
    end

endmodule

// File: tb/tb_axi4_sync_fifo.sv
// tb_axi4_sync_fifo: scoreboard bench for axi4_sync_fifo at default parameters (32 x 16).
module tb_axi4_sync_fifo;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        push_i = 1'b0;
    logic [31:0] data_in_i = '0;
    logic        pop_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] data_out_o;
    logic        valid_o;
    logic        full_o;
    logic        afull_o;
    logic [4:0]  level_o;
`ifdef AXI4_SYNC_FIFO_ERR_EN
    logic        err_o;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb [$];
    logic [31:0] got_head;
    logic [31:0] exp_head;
    bit          popped;

    axi4_sync_fifo #(
        .WIDTH        (32),
        .DEPTH        (16),
        .ADDR_W       (4),
        .AFULL_THRESH (12)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push_i),
        .data_in_i  (data_in_i),
        .pop_i      (pop_i),
        .flush_i    (flush_i),
        .data_out_o (data_out_o),
        .valid_o    (valid_o),
        .full_o     (full_o),
        .afull_o    (afull_o),
        .level_o    (level_o)
`ifdef AXI4_SYNC_FIFO_ERR_EN
        ,
        .err_o      (err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // One clock of stimulus; the scoreboard is updated with the model's accept decisions.
    task automatic drive(input logic psh, input logic [31:0] d, input logic pp, input logic fl);
        bit pa;
        bit qa;
        push_i    = psh;
        data_in_i = d;
        pop_i     = pp;
        flush_i   = fl;
        pa        = psh && (sb.size() < 16);
        qa        = pp && (sb.size() > 0);
        popped    = 1'b0;
        if (qa && !fl) begin
            got_head = data_out_o;
            exp_head = sb[0];
            popped   = 1'b1;
        end
        @(posedge clk_i);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (qa) void'(sb.pop_front());
            if (pa) sb.push_back(d);
        end
        push_i  = 1'b0;
        pop_i   = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({valid_o, full_o, afull_o, level_o} !== 8'h00 || data_out_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b full=%0b afull=%0b level=%0d data=%0h, want all 0",
                     valid_o, full_o, afull_o, level_o, data_out_o);
        end
`ifdef AXI4_SYNC_FIFO_ERR_EN
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %0b want 0", err_o);
        end
`endif
        rst_i = 1'b0;
        sb.delete();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single();
        drive(1'b1, 32'hA5, 1'b0, 1'b0);
        n_checks++;
        if (valid_o !== 1'b1 || data_out_o !== 32'hA5 || level_o !== 5'd1) begin
            n_fail++;
            $display("FAIL single_push: valid=%0b data=%0h level=%0d, want 1 a5 1",
                     valid_o, data_out_o, level_o);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (!popped || got_head !== exp_head || valid_o !== 1'b0 || level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pop: head=%0h want %0h valid=%0b level=%0d want 0 0",
                     got_head, exp_head, valid_o, level_o);
        end
        // Pop on empty must be ignored.
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (valid_o !== 1'b0 || level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL underflow_ignored: valid=%0b level=%0d want 0 0", valid_o, level_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0);
            n_checks++;
            if (level_o !== 5'(i + 1) || afull_o !== (i + 1 >= 12) || full_o !== (i + 1 == 16)
                || valid_o !== 1'b1 || data_out_o !== 32'h0) begin
                n_fail++;
                $display("FAIL fill_%0d: level=%0d afull=%0b full=%0b valid=%0b head=%0h want %0d %0b %0b 1 0",
                         i, level_o, afull_o, full_o, valid_o, data_out_o, i + 1,
                         (i + 1 >= 12), (i + 1 == 16));
            end
        end
        drive(1'b1, 32'hFF, 1'b0, 1'b0);
        n_checks++;
        if (level_o !== 5'd16 || full_o !== 1'b1 || sb.size() != 16) begin
            n_fail++;
            $display("FAIL overflow_drop: level=%0d full=%0b want 16 1", level_o, full_o);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++;
            if (!popped || got_head !== 32'(i) || got_head !== exp_head || level_o !== 5'(15 - i)) begin
                n_fail++;
                $display("FAIL drain_%0d: head=%0h want %0h level=%0d want %0d",
                         i, got_head, i, level_o, 15 - i);
            end
        end
        n_checks++;
        if (valid_o !== 1'b0 || full_o !== 1'b0 || afull_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%0b full=%0b afull=%0b want 0 0 0",
                     valid_o, full_o, afull_o);
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
            n_checks++;
            if (!popped || got_head !== exp_head || level_o !== 5'd3 || valid_o !== 1'b1) begin
                n_fail++;
                errs++;
                if (errs < 8)
                    $display("FAIL stream_%0d: head=%0h want %0h level=%0d want 3",
                             i, got_head, exp_head, level_o);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++;
            if (!popped || got_head !== 32'h200 + 32'(97 + i)) begin
                n_fail++;
                $display("FAIL stream_tail_%0d: head=%0h want %0h", i, got_head, 32'h200 + 97 + i);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
        n_checks++;
        if (level_o !== 5'd10) begin
            n_fail++;
            $display("FAIL flush_prefill: level=%0d want 10", level_o);
        end
        drive(1'b1, 32'h99, 1'b0, 1'b1);
        n_checks++;
        if (level_o !== 5'd0 || valid_o !== 1'b0 || afull_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: level=%0d valid=%0b afull=%0b want 0 0 0",
                     level_o, valid_o, afull_o);
        end
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (!popped || got_head !== 32'h11 || level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL flush_readback: head=%0h want 11 level=%0d want 0", got_head, level_o);
        end
    endtask

    task automatic test_full_push_pop();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef AXI4_SYNC_FIFO_ERR_EN
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_flush_clear: got %0b want 0", err_o);
        end
`endif
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hEE, 1'b1, 1'b0);
        n_checks++;
        if (!popped || got_head !== 32'h300 || level_o !== 5'd15 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop: head=%0h want 300 level=%0d want 15 full=%0b want 0",
                     got_head, level_o, full_o);
        end
`ifdef AXI4_SYNC_FIFO_ERR_EN
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_overflow: got %0b want 1", err_o);
        end
`endif
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++;
            if (!popped || got_head !== 32'h300 + 32'(i)) begin
                n_fail++;
                $display("FAIL full_drain_%0d: head=%0h want %0h", i, got_head, 32'h300 + i);
            end
        end
        n_checks++;
        if (valid_o !== 1'b0 || level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL full_drain_empty: valid=%0b level=%0d want 0 0", valid_o, level_o);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
        n_checks++;
        if (level_o !== 5'd7) begin
            n_fail++;
            $display("FAIL areset_prefill: level=%0d want 7", level_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (level_o !== 5'd0 || valid_o !== 1'b0 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: level=%0d valid=%0b full=%0b want 0 0 0",
                     level_o, valid_o, full_o);
        end
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(1'b1, 32'h33, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (!popped || got_head !== 32'h33 || level_o !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset_rw: head=%0h want 33 level=%0d want 0", got_head, level_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_full_push_pop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
